top_conv_3x3: RTL and testbench

Streaming 3x3 2-D convolution engine for 8-bit greyscale images. It sits between the pixel source (raster-order stream) and the feature consumer in the edge-learning datapath. It latches a 9-coefficient kernel after reset, then convolves the incoming frame with no padding (valid mode) and emits one scaled, saturated 8-bit result per fully-covered window.

---
 rtl/top_conv_3x3.sv | 113 +++++++++++
 tb/tb_top_conv_3x3.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/top_conv_3x3.sv
// top_conv_3x3: streaming 3x3 valid-mode convolution of an 8-bit raster image
// with a kernel loaded once after reset, then shifted and clamped to 8 bits.
module top_conv_3x3 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int SHIFT = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [143:0] k_val,
    input  logic [7:0]   pixel_i,
    input  logic         pix_data_valid,
    output logic [7:0]   pixel_o,
    output logic         kernel_constructed,
    output logic         conv_finished
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic {KLOAD, RUN} state_t;

    state_t             r_state, w_next;
    logic [3:0]         r_kidx;
    logic signed [15:0] r_k [9];
    logic [7:0]         r_win [9];
    logic [7:0]         r_lb0 [IMG_W];
    logic [7:0]         r_lb1 [IMG_W];
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic               r_v0, r_v1;
    logic signed [24:0] r_prod [9];
    logic               w_load, w_acc, w_ok;
    logic signed [28:0] w_sum, w_shift;
    logic [7:0]         w_clamp;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) r_state <= KLOAD;
        else         r_state <= w_next;

    always_comb w_next = (r_state == KLOAD && r_kidx == 4'd8) ? RUN : r_state;

    always_comb begin
        w_load             = r_state == KLOAD;
        kernel_constructed = r_state == RUN;
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_kidx <= '0;
            for (int i = 0; i < 9; i++) r_k[i] <= '0;
        end else if (w_load) begin
            r_kidx <= r_kidx + 4'd1;
            for (int i = 0; i < 9; i++)
                if (r_kidx == 4'(i)) r_k[i] <= k_val[16*i +: 16];
        end

    always_comb begin
        w_acc = pix_data_valid && kernel_constructed;
        w_ok  = r_row >= RW'(2) && r_col >= CW'(2);
    end

    // Window index = row*3+col; row 0 is two lines back, col 0 the oldest pixel.
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_col <= '0;
            r_row <= '0;
            r_v0  <= 1'b0;
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
        end else begin
            r_v0 <= w_acc && w_ok;
            if (w_acc) begin
                r_col <= (r_col == CW'(IMG_W-1)) ? '0 : r_col + 1'b1;
                if (r_col == CW'(IMG_W-1))
                    r_row <= (r_row == RW'(IMG_H-1)) ? '0 : r_row + 1'b1;
                r_lb1[r_col] <= r_lb0[r_col];
                r_lb0[r_col] <= pixel_i;
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= r_lb1[r_col];
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= r_lb0[r_col];
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pixel_i;
            end
        end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 9; i++) w_sum = w_sum + {{4{r_prod[i][24]}}, r_prod[i]};
        w_shift = w_sum >>> SHIFT;
        w_clamp = w_shift[28] ? 8'd0 : (|w_shift[27:8]) ? 8'd255 : w_shift[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            r_v1          <= 1'b0;
            conv_finished <= 1'b0;
            pixel_o       <= '0;
            for (int i = 0; i < 9; i++) r_prod[i] <= '0;
        end else begin
            r_v1          <= r_v0;
            conv_finished <= r_v1;
            for (int i = 0; i < 9; i++)
                r_prod[i] <= $signed({17'd0, r_win[i]}) * $signed({{9{r_k[i][15]}}, r_k[i]});
            if (r_v1) pixel_o <= w_clamp;
        end
endmodule

// File: tb/tb_top_conv_3x3.sv
// tb_top_conv_3x3: directed checks of kernel load, constant/ramp/gapped frames,
// frame boundaries, saturation and mid-frame reset.
module tb_top_conv_3x3;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [143:0] k_val;
    logic [7:0]   pixel_i = '0;
    logic         pix_data_valid = 1'b0;
    logic [7:0]   pixel_o;
    logic         kernel_constructed;
    logic         conv_finished;

    localparam logic [143:0] K_GAUSS = {16'd1, 16'd2, 16'd1, 16'd2, 16'd4, 16'd2, 16'd1, 16'd2, 16'd1};
    localparam logic [143:0] K_CPOS  = 144'h0100 << 64;
    localparam logic [143:0] K_CNEG  = 144'hFFFF << 64;

    int         n_vec = 0, n_err = 0, cyc = 0, first_cyc = -1, acc58 = -1;
    logic [7:0] q_out [$];
    int         q_exp [$];

    top_conv_3x3 dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .k_val(k_val), .pixel_i(pixel_i),
        .pix_data_valid(pix_data_valid), .pixel_o(pixel_o),
        .kernel_constructed(kernel_constructed), .conv_finished(conv_finished)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i)
        if (rst_ni && conv_finished) begin
            q_out.push_back(pixel_o);
            if (first_cyc < 0) first_cyc = cyc;
        end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            pix_data_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input bit ramp, input int v, input int e, input bit gaps);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                if (gaps) idle($urandom_range(0, 2));
                @(negedge clk_i);
                pix_data_valid = 1'b1;
                pixel_i = ramp ? 8'(c) : 8'(v);
                if (r * 28 + c == 58 && acc58 < 0) acc58 = cyc + 1;
                if (r >= 2 && c >= 2) q_exp.push_back(ramp ? c - 1 : e);
            end
    endtask

    task automatic check_out(input string tag, input int n);
        chk({tag, "_count"}, q_out.size(), n);
        for (int i = 0; i < q_out.size() && i < q_exp.size(); i++) chk(tag, q_out[i], q_exp[i]);
        q_out.delete();
        q_exp.delete();
    endtask

    task automatic do_reset(input logic [143:0] k);
        @(negedge clk_i);
        rst_ni = 1'b0;
        pix_data_valid = 1'b0;
        k_val = k;
        @(negedge clk_i);
        q_out.delete();
        q_exp.delete();
        rst_ni = 1'b1;
        idle(11);
    endtask

    initial begin
        k_val = K_GAUSS;
        idle(3);
        chk("rst_pixel_o", pixel_o, 0);
        chk("rst_conv_finished", conv_finished, 0);
        chk("rst_kernel_constructed", kernel_constructed, 0);

        // Valid pulses during kernel load must be ignored.
        @(negedge clk_i);
        rst_ni = 1'b1;
        pix_data_valid = 1'b1;
        pixel_i = 8'd200;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk_i);
            #1;
            chk("kc_edge", kernel_constructed, 32'(e >= 9));
            if (e == 8) pix_data_valid = 1'b0;
        end
        idle(6);
        chk("kload_no_out", q_out.size(), 0);

        first_cyc = -1;
        acc58 = -1;
        send_frame(0, 100, 100, 0);
        send_frame(1, 0, 0, 0);
        idle(5);
        chk("first_latency", 32'(first_cyc - acc58), 2);
        check_out("const_ramp", 1352);
        chk("hold_pixel_o", pixel_o, 26);
        chk("hold_conv_finished", conv_finished, 0);

        send_frame(0, 100, 100, 1);
        idle(5);
        check_out("gapped", 676);

        repeat (300) begin
            @(negedge clk_i);
            pix_data_valid = 1'b1;
            pixel_i = 8'd100;
        end
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("midrst_pixel_o", pixel_o, 0);
        chk("midrst_conv_finished", conv_finished, 0);
        chk("midrst_kernel_constructed", kernel_constructed, 0);
        @(negedge clk_i);
        pix_data_valid = 1'b0;
        q_out.delete();
        q_exp.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle(11);
        chk("reload_kernel_constructed", kernel_constructed, 1);
        send_frame(0, 100, 100, 0);
        idle(5);
        check_out("after_reset", 676);

        do_reset(K_CPOS);
        send_frame(0, 255, 255, 0);
        send_frame(0, 10, 160, 0);
        idle(5);
        check_out("sat_hi", 1352);

        do_reset(K_CNEG);
        send_frame(0, 255, 0, 0);
        idle(5);
        check_out("sat_lo", 676);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
